mvm_row_group_scheduler: RTL and testbench

- Sequences the matrix-by-vector engine over a full job, one row group at a time.
- Each row group holds NO_OF_ROW_BY_VECTOR_MODULES rows.
- Per group it requests the A-row and vector slices from the memories, starts the row-by-vector lanes, collects their sticky completion flags, hands the group result to the decoder, and loops.
- Sits between the top-level job control and the matrix_by_vector datapath. It replaces the ad-hoc group counting with an explicit FSM.

---
 rtl/mvm_row_group_scheduler_if.sv | 32 +++
 rtl/mvm_row_group_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mvm_row_group_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_row_group_scheduler_if.sv
// Job, memory, lane and decoder handshake bundle for the row-group scheduler.
// master = scheduler side, slave = job control / memories / lanes / decoder side.
interface mvm_row_group_scheduler_if #(
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = 4
);
    logic                                      start;
    logic [31:0]                               total_rows;
    logic [31:0]                               row_len;
    logic                                      mem_req;
    logic [31:0]                               mem_row_base;
    logic                                      mem_ready;
    logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]    lane_start;
    logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]    lane_enable;
    logic [NO_OF_ROW_BY_VECTOR_MODULES*32-1:0] no_of_multiples;
    logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]    lane_done;
    logic                                      out_ready;
    logic                                      out_valid;
    logic                                      busy;
    logic                                      finish;

    modport master (
        input  start, total_rows, row_len, mem_ready, lane_done, out_ready,
        output mem_req, mem_row_base, lane_start, lane_enable, no_of_multiples,
               out_valid, busy, finish
    );

    modport slave (
        output start, total_rows, row_len, mem_ready, lane_done, out_ready,
        input  mem_req, mem_row_base, lane_start, lane_enable, no_of_multiples,
               out_valid, busy, finish
    );
endinterface

// File: rtl/mvm_row_group_scheduler.sv
// Row-group scheduler for the matrix-by-vector engine: fetch, launch, collect, drain, loop.
// Optional macro MVM_SCHED_PERF_CNT_EN adds perf_busy_cycles / perf_stall_cycles outputs.
module mvm_row_group_scheduler #(
    parameter int ELEMENT_WIDTH               = 32,
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = 4,
    parameter int NI                          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    mvm_row_group_scheduler_if.master    bus
`ifdef MVM_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_busy_cycles,
    output logic [31:0]                  perf_stall_cycles
`endif
);
    localparam int NL    = NO_OF_ROW_BY_VECTOR_MODULES;
    localparam int LOG2N = (NL > 1) ? $clog2(NL) : 0;

    if (((NL & (NL - 1)) != 0) || (ELEMENT_WIDTH <= 0) || (NI <= 0)) begin : g_bad_param
        $error("mvm_row_group_scheduler: lane count must be a power of two, widths positive");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [31:0]        r_total, r_mult, r_groups, r_g, r_row_base;
    logic               r_req_sent;
    logic [NL-1:0]      r_lane_en, r_sticky, w_lane_en, w_done_masked;
    logic [NL*32-1:0]   r_nmul, w_nmul;
    logic [32:0]        w_mult33, w_grp33;
    logic               w_all_done, w_mem_req, w_out_valid, w_busy, w_finish;
    logic [NL-1:0]      w_lane_start;

    assign w_mult33      = ({1'b0, bus.row_len} + 33'(NI - 1)) / 33'(NI);
    assign w_grp33       = ({1'b0, bus.total_rows} + 33'(NL - 1)) >> LOG2N;
    assign w_done_masked = bus.lane_done & r_lane_en;
    // The last pulse may complete the group in the same cycle it arrives.
    assign w_all_done    = ((r_sticky | w_done_masked) == r_lane_en);

    always_comb begin
        w_lane_en = '0;
        w_nmul    = '0;
        for (int k = 0; k < NL; k++) begin
            w_lane_en[k]      = (({1'b0, r_row_base} + 33'(k)) < {1'b0, r_total});
            w_nmul[k*32 +: 32] = w_lane_en[k] ? r_mult : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_lane_start = '0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        w_finish     = 1'b0;
        if (!bus.start) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next = ((bus.total_rows == 32'd0) || (bus.row_len == 32'd0)) ? S_DONE : S_FETCH;
                end
                S_FETCH: begin
                    w_busy    = 1'b1;
                    w_mem_req = !r_req_sent;
                    if (bus.mem_ready) w_next = S_LAUNCH;
                end
                S_LAUNCH: begin
                    w_busy       = 1'b1;
                    w_lane_start = r_lane_en;
                    w_next       = S_WAIT;
                end
                S_WAIT: begin
                    w_busy = 1'b1;
                    if (w_all_done) w_next = S_DRAIN;
                end
                S_DRAIN: begin
                    w_busy = 1'b1;
                    if (bus.out_ready) begin
                        w_out_valid = 1'b1;
                        w_next      = ((r_g + 32'd1) == r_groups) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    w_finish = 1'b1;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.start) begin
            r_total    <= '0;
            r_mult     <= '0;
            r_groups   <= '0;
            r_g        <= '0;
            r_row_base <= '0;
            r_req_sent <= 1'b0;
            r_lane_en  <= '0;
            r_sticky   <= '0;
            r_nmul     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_total    <= bus.total_rows;
                    r_mult     <= w_mult33[31:0];
                    r_groups   <= w_grp33[31:0];
                    r_g        <= '0;
                    r_row_base <= '0;
                    r_req_sent <= 1'b0;
                    r_sticky   <= '0;
                end
                S_FETCH: begin
                    r_req_sent <= 1'b1;
                    if (bus.mem_ready) begin
                        r_lane_en <= w_lane_en;
                        r_nmul    <= w_nmul;
                    end
                end
                S_LAUNCH: r_sticky <= '0;
                S_WAIT:   r_sticky <= r_sticky | w_done_masked;
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        r_g        <= r_g + 32'd1;
                        r_row_base <= r_row_base + 32'(NL);
                        r_req_sent <= 1'b0;
                        r_lane_en  <= '0;
                        r_nmul     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MVM_SCHED_PERF_CNT_EN
    logic w_stall;
    assign w_stall = bus.start && (((r_state == S_FETCH) && !bus.mem_ready) ||
                                   ((r_state == S_DRAIN) && !bus.out_ready));

    always_ff @(posedge clk) begin
        if (reset || ((r_state == S_IDLE) && bus.start)) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (w_busy)  perf_busy_cycles  <= perf_busy_cycles + 32'd1;
            if (w_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

    assign bus.mem_req         = w_mem_req;
    assign bus.mem_row_base    = r_row_base;
    assign bus.lane_start      = w_lane_start;
    assign bus.lane_enable     = r_lane_en;
    assign bus.no_of_multiples = r_nmul;
    assign bus.out_valid       = w_out_valid;
    assign bus.busy            = w_busy;
    assign bus.finish          = w_finish;
endmodule

// File: tb/tb_mvm_row_group_scheduler.sv
// Directed bench for mvm_row_group_scheduler: full/partial groups, staggered done, degenerate, abort, reset.
module tb_mvm_row_group_scheduler;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_req = 0, n_ls = 0, n_ov = 0;

    mvm_row_group_scheduler_if #(.NO_OF_ROW_BY_VECTOR_MODULES(NL)) bif ();

`ifdef MVM_SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    mvm_row_group_scheduler #(
        .ELEMENT_WIDTH(32), .NO_OF_ROW_BY_VECTOR_MODULES(NL), .NI(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
`ifdef MVM_SCHED_PERF_CNT_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.mem_req)           n_req++;
        if (bif.lane_start != '0)  n_ls++;
        if (bif.out_valid)         n_ov++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_mul(input logic [3:0] en, input logic [31:0] m);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) r[k*32 +: 32] = en[k] ? m : 32'd0;
        return r;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   bif.busy, 0);
        chk({tag, "_finish"}, bif.finish, 0);
        chk({tag, "_req"},    bif.mem_req, 0);
        chk({tag, "_base"},   bif.mem_row_base, 0);
        chk({tag, "_en"},     bif.lane_enable, 0);
        chk({tag, "_ls"},     bif.lane_start, 0);
        chk({tag, "_nmul"},   bif.no_of_multiples, 0);
        chk({tag, "_ov"},     bif.out_valid, 0);
    endtask

    // dly holds, per lane (lane 0 in the low byte), the cycle after lane_start at which
    // lane_done pulses; 0 means no pulse.
    task automatic run_group(input string tag, input logic [31:0] base, input logic [3:0] en,
                             input logic [31:0] mul, input int mr_dly, input logic [31:0] dly,
                             input bit or_early, input int or_dly, input bit last);
        int t;
        int maxd;
        logic [3:0] d;
        t = 0;
        while (bif.mem_req !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_req"},  bif.mem_req, 1);
        chk({tag, "_base"}, bif.mem_row_base, base);
        for (int i = 0; i < mr_dly; i++) begin
            tick();
            chk({tag, "_req_once"}, bif.mem_req, 0);
        end
        bif.mem_ready = 1'b1;
        tick();
        bif.mem_ready = 1'b0;
        chk({tag, "_ls"},   bif.lane_start, en);
        chk({tag, "_en"},   bif.lane_enable, en);
        chk({tag, "_nmul"}, bif.no_of_multiples, exp_mul(en, mul));
        maxd = 0;
        for (int k = 0; k < NL; k++) if (int'(dly[k*8 +: 8]) > maxd) maxd = int'(dly[k*8 +: 8]);
        if (or_early) bif.out_ready = 1'b1;
        for (int c = 1; c <= maxd; c++) begin
            tick();
            d = '0;
            for (int k = 0; k < NL; k++) if (int'(dly[k*8 +: 8]) == c) d[k] = 1'b1;
            bif.lane_done = d;
            #1;
            chk({tag, "_wait_ov"}, bif.out_valid, 0);
        end
        tick();
        bif.lane_done = '0;
        if (!or_early) begin
            for (int i = 0; i < or_dly; i++) begin
                #1;
                chk({tag, "_hold_ov"}, bif.out_valid, 0);
                tick();
            end
            bif.out_ready = 1'b1;
        end
        #1;
        chk({tag, "_ov"},      bif.out_valid, 1);
        chk({tag, "_en_hold"}, bif.lane_enable, en);
        tick();
        bif.out_ready = 1'b0;
        if (last) begin
            chk({tag, "_finish"}, bif.finish, 1);
            chk({tag, "_busy"},   bif.busy, 0);
        end
    endtask

    initial begin
        int s_req, s_ls, s_ov;
        bif.start      = 1'b0;
        bif.total_rows = '0;
        bif.row_len    = '0;
        bif.mem_ready  = 1'b0;
        bif.lane_done  = '0;
        bif.out_ready  = 1'b0;
        repeat (3) tick();
        chk_idle("rst");
        reset = 1'b0;
        tick();

        // Two full groups, mult = 2
        s_req = n_req; s_ov = n_ov;
        bif.total_rows = 32'd8; bif.row_len = 32'd16; bif.start = 1'b1;
        tick();
        chk("t1_lat_req", bif.mem_req, 1);
        run_group("t1g0", 32'd0, 4'hF, 32'd2, 2, {8'd3, 8'd3, 8'd3, 8'd3}, 1'b1, 0, 1'b0);
        run_group("t1g1", 32'd4, 4'hF, 32'd2, 2, {8'd3, 8'd3, 8'd3, 8'd3}, 1'b1, 0, 1'b1);
        chk("t1_nreq", 32'(n_req - s_req), 2);
        chk("t1_nov",  32'(n_ov - s_ov), 2);
`ifdef MVM_SCHED_PERF_CNT_EN
        chk("t1_perf_stall", perf_stall_cycles, 4);
        chk("t1_perf_busy",  perf_busy_cycles, 16);
`endif
        bif.start = 1'b0;
        tick();
        chk("t1_idle_finish", bif.finish, 0);

        // Partial second group with rounding; stray done on disabled lane 3
        bif.total_rows = 32'd6; bif.row_len = 32'd17; bif.start = 1'b1;
        tick();
        run_group("t2g0", 32'd0, 4'hF, 32'd3, 1, {8'd2, 8'd2, 8'd1, 8'd1}, 1'b1, 0, 1'b0);
        run_group("t2g1", 32'd4, 4'h3, 32'd3, 1, {8'd1, 8'd0, 8'd2, 8'd2}, 1'b1, 0, 1'b1);
        bif.start = 1'b0;
        tick();

        // Staggered done (5,5,7,9) then a 4-cycle out_ready hold
        bif.total_rows = 32'd8; bif.row_len = 32'd8; bif.start = 1'b1;
        tick();
        run_group("t3g0", 32'd0, 4'hF, 32'd1, 1, {8'd9, 8'd7, 8'd5, 8'd5}, 1'b1, 0, 1'b0);
        run_group("t3g1", 32'd4, 4'hF, 32'd1, 2, {8'd3, 8'd3, 8'd3, 8'd3}, 1'b0, 4, 1'b1);
`ifdef MVM_SCHED_PERF_CNT_EN
        chk("t3_perf_stall", perf_stall_cycles, 7);
        tick();
        chk("t3_perf_hold", perf_stall_cycles, 7);
`endif
        bif.start = 1'b0;
        tick();

        // Degenerate jobs
        for (int j = 0; j < 2; j++) begin
            s_req = n_req; s_ls = n_ls; s_ov = n_ov;
            bif.total_rows = (j == 0) ? 32'd0 : 32'd5;
            bif.row_len    = (j == 0) ? 32'd16 : 32'd0;
            bif.start      = 1'b1;
            tick();
            tick();
            chk("t4_finish", bif.finish, 1);
            chk("t4_busy",   bif.busy, 0);
            chk("t4_nreq", 32'(n_req - s_req), 0);
            chk("t4_nls",  32'(n_ls - s_ls), 0);
            chk("t4_nov",  32'(n_ov - s_ov), 0);
            bif.start = 1'b0;
            tick();
            chk("t4_cleared", bif.finish, 0);
        end

        // Abort during WAIT of group 1, then restart from group 0
        bif.total_rows = 32'd8; bif.row_len = 32'd8; bif.start = 1'b1;
        tick();
        run_group("t5g0", 32'd0, 4'hF, 32'd1, 0, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, 0, 1'b0);
        chk("t5_g1_base", bif.mem_row_base, 4);
        bif.mem_ready = 1'b1;
        tick();
        bif.mem_ready = 1'b0;
        tick();
        chk("t5_wait_busy", bif.busy, 1);
        bif.start = 1'b0;
        tick();
        chk_idle("t5_abort");
        bif.start = 1'b1;
        tick();
        chk("t5_restart_req",  bif.mem_req, 1);
        chk("t5_restart_base", bif.mem_row_base, 0);
        bif.start = 1'b0;
        tick();

        // Reset asserted while in DRAIN
        bif.total_rows = 32'd4; bif.row_len = 32'd8; bif.start = 1'b1;
        tick();
        bif.mem_ready = 1'b1;
        tick();
        bif.mem_ready = 1'b0;
        tick();
        bif.lane_done = 4'hF;
        tick();
        bif.lane_done = '0;
        chk("t6_drain_busy", bif.busy, 1);
        chk("t6_drain_en",   bif.lane_enable, 4'hF);
        reset = 1'b1;
        tick();
        bif.out_ready = 1'b1;
        #1;
        chk_idle("t6_rst");
`ifdef MVM_SCHED_PERF_CNT_EN
        chk("t6_perf_busy",  perf_busy_cycles, 0);
        chk("t6_perf_stall", perf_stall_cycles, 0);
`endif
        bif.out_ready = 1'b0;
        bif.start = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
